wb_regfile: RTL

- Write-back consumer of the MEM/WB stage register.
- Holds the 32x32 GPR file and the HI/LO registers, and commits the wb_* write requests into them.
- Serves two combinational GPR read ports and a HI/LO read port to the decode/execute stages, with same-cycle write-through bypass.
- Drives the debug trace bus and a retired-instruction counter, both fed from the committed write-back stream.

---
 rtl/wb_regfile_if.sv | 63 ++++++
 rtl/wb_regfile.sv | 125 ++++++++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile_if
//  Description : Bundle between the write-back stage, the register file, the
//                decode/execute read ports and the debug trace.
//                slave  - the register file (consumes wb_* and read addresses)
//                master - the pipeline side (drives wb_* and read addresses)
//                Ports carried: wb_* write requests and wb_pc, rs/rt read
//                ports, hi/lo read data, debug_wb_* trace and retire_count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Write-back requests from the MEM/WB stage register
  logic                  wb_regfile_write_enable;
  logic [ADDR_WIDTH-1:0] wb_regfile_write_addr;
  logic [DATA_WIDTH-1:0] wb_regfile_write_data;
  logic                  wb_hi_write_enable;
  logic [DATA_WIDTH-1:0] wb_hi_write_data;
  logic                  wb_lo_write_enable;
  logic [DATA_WIDTH-1:0] wb_lo_write_data;
  logic [DATA_WIDTH-1:0] wb_pc;

  // Read ports
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [DATA_WIDTH-1:0] rt_data;
  logic [DATA_WIDTH-1:0] hi_data;
  logic [DATA_WIDTH-1:0] lo_data;

  // Debug trace and retirement counter
  logic [DATA_WIDTH-1:0] debug_wb_pc;
  logic [3:0]            debug_wb_rf_wen;
  logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum;
  logic [DATA_WIDTH-1:0] debug_wb_rf_wdata;
  logic [31:0]           retire_count;

  modport slave (
    input  wb_regfile_write_enable, wb_regfile_write_addr, wb_regfile_write_data,
    input  wb_hi_write_enable, wb_hi_write_data,
    input  wb_lo_write_enable, wb_lo_write_data,
    input  wb_pc,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, hi_data, lo_data,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output retire_count
  );

  modport master (
    output wb_regfile_write_enable, wb_regfile_write_addr, wb_regfile_write_data,
    output wb_hi_write_enable, wb_hi_write_data,
    output wb_lo_write_enable, wb_lo_write_data,
    output wb_pc,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, hi_data, lo_data,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  retire_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Write-back consumer of the MEM/WB stage register. Holds the
//                GPR file and HI/LO, commits wb_* requests on the rising edge,
//                serves two combinational GPR read ports and HI/LO reads with
//                same-cycle write-through bypass, and drives the debug trace
//                and a retired-instruction counter.
//  Ports       : clk - system clock
//                rst - synchronous reset, active-high
//                bus - wb_regfile_if.slave (write-back, read ports, trace)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int GPR_NUM    = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  // The address decode assumes every address maps to exactly one register.
  generate
    if (GPR_NUM != (1 << ADDR_WIDTH)) begin : g_bad_gpr_num
      $error("wb_regfile: GPR_NUM must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] gpr_q [GPR_NUM];
  logic [DATA_WIDTH-1:0] gpr_d [GPR_NUM];
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [31:0]           retire_count_q, retire_count_d;

  logic                  gpr_wr;

  // $0 is never written, so gpr_q[0] stays at its reset value of zero; the
  // read mux still forces zero explicitly so $0 never depends on storage.
  assign gpr_wr = bus.wb_regfile_write_enable &&
                  (bus.wb_regfile_write_addr != '0);

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    gpr_d = gpr_q;
    if (gpr_wr) begin
      gpr_d[bus.wb_regfile_write_addr] = bus.wb_regfile_write_data;
    end

    hi_d = bus.wb_hi_write_enable ? bus.wb_hi_write_data : hi_q;
    lo_d = bus.wb_lo_write_enable ? bus.wb_lo_write_data : lo_q;

    // A zero PC is a pipeline bubble; every other WB slot retires, whether
    // or not it writes a register (branches and stores count too).
    retire_count_d = retire_count_q;
    if (bus.wb_pc != '0) begin
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GPR_NUM; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q           <= '0;
      lo_q           <= '0;
      retire_count_q <= '0;
    end else begin
      gpr_q          <= gpr_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      retire_count_q <= retire_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: $0 reads zero, else the in-flight write wins over storage so
  // decode sees the value being committed this same cycle.
  // --------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] gpr_read(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (addr == '0) begin
      return '0;
    end else if (wr_en && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  assign bus.rs_data = gpr_read(bus.rs_addr, bus.wb_regfile_write_enable,
                                bus.wb_regfile_write_addr,
                                bus.wb_regfile_write_data, gpr_q[bus.rs_addr]);
  assign bus.rt_data = gpr_read(bus.rt_addr, bus.wb_regfile_write_enable,
                                bus.wb_regfile_write_addr,
                                bus.wb_regfile_write_data, gpr_q[bus.rt_addr]);

  assign bus.hi_data = bus.wb_hi_write_enable ? bus.wb_hi_write_data : hi_q;
  assign bus.lo_data = bus.wb_lo_write_enable ? bus.wb_lo_write_data : lo_q;

  // --------------------------------------------------------------------------
  // Trace: straight pass-through of the slot being committed on this edge.
  // Writes to $0 are still reported so the trace matches the instruction.
  // --------------------------------------------------------------------------
  assign bus.debug_wb_pc       = bus.wb_pc;
  assign bus.debug_wb_rf_wen   = {4{bus.wb_regfile_write_enable}};
  assign bus.debug_wb_rf_wnum  = bus.wb_regfile_write_addr;
  assign bus.debug_wb_rf_wdata = bus.wb_regfile_write_data;

  assign bus.retire_count = retire_count_q;

endmodule
`default_nettype wire
